// File: rtl/multicycle_controller_if.sv
// Memory handshake between the multi-cycle controller and the shared
// instruction/data memory.
interface multicycle_controller_if;
  logic mem_read;
  logic mem_write;
  logic adr_select;
  logic mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output adr_select,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  adr_select,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I datapath: sequences fetch/decode/
// execute, handshakes with shared memory, counts retires and traps.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | classify opcode, precompute branch target into ALUOut
// MEMADR   | compute rs1+imm for lw/sw
// MEMREAD  | load access, wait for mem_ready
// MEMWB    | write load data to rd
// MEMWRITE | store access, wait for mem_ready
// EXECUTER | register-register ALU op
// ALUWB    | write ALUOut to rd
// EXECUTEI | register-immediate ALU op
// JAL      | PC <= target, ALUOut <= oldPC+4
// BEQ      | compare rs1/rs2, PC <= target when zero
// TRAP     | illegal instruction or memory timeout; only reset exits
module multicycle_controller #(
  parameter int COUNT_WIDTH = 32,
  parameter int WAIT_LIMIT  = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic                   funct7b5,
  input  logic                   zero,
  multicycle_controller_if.master mem,
  output logic                   IR_write,
  output logic                   PC_write,
  output logic                   reg_write,
  output logic [1:0]             result_select,
  output logic [1:0]             ALU_srcA,
  output logic [1:0]             ALU_srcB,
  output logic [2:0]             ALU_control,
  output logic                   retired,
  output logic [COUNT_WIDTH-1:0] instret,
  output logic [1:0]             trap_cause,
  output logic [3:0]             state
);

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECUTER = 4'd6,
    ST_ALUWB    = 4'd7,
    ST_EXECUTEI = 4'd8,
    ST_JAL      = 4'd9,
    ST_BEQ      = 4'd10,
    ST_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam int             WW       = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [WW-1:0]  WAIT_MAX = WW'(WAIT_LIMIT);

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] instret_q, instret_d;
  logic [1:0]             trap_cause_q, trap_cause_d;
  logic [WW-1:0]          wait_cnt_q, wait_cnt_d;

  logic       mem_read_c, mem_write_c, adr_select_c;
  logic       ir_write_c, pc_write_c, reg_write_c, retired_c;
  logic [1:0] result_select_c, alu_srca_c, alu_srcb_c;
  logic [2:0] alu_control_c;
  logic       waiting, timeout, funct3_ok;

  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic is_r,
                                            input logic f7b5);
    case (f3)
      3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  always_comb begin
    state_d         = state_q;
    trap_cause_d    = trap_cause_q;
    wait_cnt_d      = wait_cnt_q;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    adr_select_c    = 1'b0;
    ir_write_c      = 1'b0;
    pc_write_c      = 1'b0;
    reg_write_c     = 1'b0;
    retired_c       = 1'b0;
    result_select_c = 2'b00;
    alu_srca_c      = 2'b00;
    alu_srcb_c      = 2'b00;
    alu_control_c   = ALU_ADD;
    waiting         = 1'b0;
    timeout         = (WAIT_LIMIT > 0) && (wait_cnt_q == WAIT_MAX);
    funct3_ok       = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                      (funct3 == 3'b110) || (funct3 == 3'b111);

    case (state_q)
      ST_FETCH: begin
        mem_read_c      = 1'b1;
        alu_srcb_c      = 2'b10;
        result_select_c = 2'b10;
        if (mem.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = ST_DECODE;
        end else begin
          waiting = 1'b1;
          if (timeout) begin
            state_d      = ST_TRAP;
            trap_cause_d = CAUSE_TIMEOUT;
          end
        end
      end
      ST_DECODE: begin
        alu_srca_c = 2'b01;
        alu_srcb_c = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_R:         state_d = funct3_ok ? ST_EXECUTER : ST_TRAP;
          OP_I:         state_d = funct3_ok ? ST_EXECUTEI : ST_TRAP;
          OP_BRANCH:    state_d = (funct3 == 3'b000) ? ST_BEQ : ST_TRAP;
          OP_JAL:       state_d = ST_JAL;
          default:      state_d = ST_TRAP;
        endcase
        if (state_d == ST_TRAP) trap_cause_d = CAUSE_ILLEGAL;
      end
      ST_MEMADR: begin
        alu_srca_c = 2'b10;
        alu_srcb_c = 2'b01;
        state_d    = (opcode == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
      end
      ST_MEMREAD: begin
        mem_read_c   = 1'b1;
        adr_select_c = 1'b1;
        if (mem.mem_ready) begin
          state_d = ST_MEMWB;
        end else begin
          waiting = 1'b1;
          if (timeout) begin
            state_d      = ST_TRAP;
            trap_cause_d = CAUSE_TIMEOUT;
          end
        end
      end
      ST_MEMWB: begin
        result_select_c = 2'b01;
        reg_write_c     = 1'b1;
        retired_c       = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_MEMWRITE: begin
        mem_write_c  = 1'b1;
        adr_select_c = 1'b1;
        if (mem.mem_ready) begin
          retired_c = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          waiting = 1'b1;
          if (timeout) begin
            state_d      = ST_TRAP;
            trap_cause_d = CAUSE_TIMEOUT;
          end
        end
      end
      ST_EXECUTER: begin
        alu_srca_c    = 2'b10;
        alu_srcb_c    = 2'b00;
        alu_control_c = alu_decode(funct3, 1'b1, funct7b5);
        state_d       = ST_ALUWB;
      end
      ST_EXECUTEI: begin
        alu_srca_c    = 2'b10;
        alu_srcb_c    = 2'b01;
        alu_control_c = alu_decode(funct3, 1'b0, funct7b5);
        state_d       = ST_ALUWB;
      end
      ST_ALUWB: begin
        result_select_c = 2'b00;
        reg_write_c     = 1'b1;
        retired_c       = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_BEQ: begin
        alu_srca_c    = 2'b10;
        alu_srcb_c    = 2'b00;
        alu_control_c = ALU_SUB;
        pc_write_c    = zero;
        retired_c     = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_JAL: begin
        // ALUOut already holds the jump target from DECODE; ALU computes oldPC+4 for rd
        alu_srca_c = 2'b01;
        alu_srcb_c = 2'b10;
        pc_write_c = 1'b1;
        state_d    = ST_ALUWB;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    instret_d = instret_q + COUNT_WIDTH'(retired_c);

    // Counter restarts on every state change, so each memory state gets a fresh budget
    if (state_d != state_q)
      wait_cnt_d = '0;
    else if (waiting && (WAIT_LIMIT > 0))
      wait_cnt_d = wait_cnt_q + WW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_FETCH;
      instret_q    <= '0;
      trap_cause_q <= CAUSE_NONE;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      instret_q    <= instret_d;
      trap_cause_q <= trap_cause_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Strobes are gated by reset so an access aborts the moment reset asserts
  assign mem.mem_read    = reset & mem_read_c;
  assign mem.mem_write   = reset & mem_write_c;
  assign mem.adr_select  = reset & adr_select_c;
  assign IR_write        = reset & ir_write_c;
  assign PC_write        = reset & pc_write_c;
  assign reg_write       = reset & reg_write_c;
  assign retired         = reset & retired_c;
  assign result_select   = reset ? result_select_c : 2'b00;
  assign ALU_srcA        = reset ? alu_srca_c : 2'b00;
  assign ALU_srcB        = reset ? alu_srcb_c : 2'b00;
  assign ALU_control     = reset ? alu_control_c : ALU_ADD;
  assign instret         = instret_q;
  assign trap_cause      = trap_cause_q;
  assign state           = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;
  localparam int CW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic [2:0]    funct3 = 3'd0;
  logic          funct7b5 = 1'b0;
  logic          zero = 1'b0;
  logic          IR_write, PC_write, reg_write, retired;
  logic [1:0]    result_select, ALU_srcA, ALU_srcB, trap_cause;
  logic [2:0]    ALU_control;
  logic [CW-1:0] instret;
  logic [3:0]    state;

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_instret = '0;

  multicycle_controller_if mem_bus();

  multicycle_controller #(.COUNT_WIDTH(CW), .WAIT_LIMIT(15)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem(mem_bus),
    .IR_write(IR_write), .PC_write(PC_write), .reg_write(reg_write),
    .result_select(result_select), .ALU_srcA(ALU_srcA), .ALU_srcB(ALU_srcB),
    .ALU_control(ALU_control), .retired(retired), .instret(instret),
    .trap_cause(trap_cause), .state(state)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents an instruction in FETCH with mem_ready=1; returns in DECODE
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op;
    funct3 = f3;
    funct7b5 = f7;
    mem_bus.mem_ready = 1'b1;
    tick();
    mem_bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    mem_bus.mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    @(negedge clock);
    reset = 1'b1;
    #1;
    exp_instret = '0;
  endtask

  task automatic test_reset();
    mem_bus.mem_ready = 1'b0;
    #2;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (instret !== '0) begin errors++; $display("FAIL reset_instret got %0d exp 0", instret); end
    checks++; if (trap_cause !== 2'b00) begin errors++; $display("FAIL reset_trap got %0d exp 0", trap_cause); end
    checks++; if (mem_bus.mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %0b exp 0", mem_bus.mem_read); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (mem_bus.mem_read !== 1'b1) begin errors++; $display("FAIL post_reset_mem_read got %0b exp 1", mem_bus.mem_read); end
    issue(7'b0100011, 3'b010, 1'b0);
    tick();
    tick();
    #1;
    checks++; if (state !== 4'd5) begin errors++; $display("FAIL sw_in_memwrite got %0d exp 5", state); end
    checks++; if (mem_bus.mem_write !== 1'b1) begin errors++; $display("FAIL sw_mem_write got %0b exp 1", mem_bus.mem_write); end
    reset = 1'b0;
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL async_reset_state got %0d exp 0", state); end
    checks++; if (mem_bus.mem_write !== 1'b0) begin errors++; $display("FAIL async_reset_mem_write got %0b exp 0", mem_bus.mem_write); end
    checks++; if (mem_bus.mem_read !== 1'b0) begin errors++; $display("FAIL async_reset_mem_read got %0b exp 0", mem_bus.mem_read); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (mem_bus.mem_read !== 1'b1) begin errors++; $display("FAIL rerelease_mem_read got %0b exp 1", mem_bus.mem_read); end
    checks++; if (instret !== '0) begin errors++; $display("FAIL aborted_sw_instret got %0d exp 0", instret); end
  endtask

  task automatic test_alu_ops();
    logic [6:0] ops [6] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0110011, 7'b0010011};
    logic [2:0] f3s [6] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b110, 3'b111};
    logic       f7s [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] sts [6] = '{4'd6, 4'd6, 4'd8, 4'd8, 4'd6, 4'd8};
    logic [2:0] alus[6] = '{3'b000, 3'b001, 3'b000, 3'b101, 3'b011, 3'b010};
    logic [1:0] srcb[6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], f3s[i], f7s[i]);
      #1;
      checks++; if (state !== 4'd1) begin errors++; $display("FAIL alu%0d_decode got %0d exp 1", i, state); end
      tick();
      #1;
      checks++; if (state !== sts[i]) begin errors++; $display("FAIL alu%0d_exec_state got %0d exp %0d", i, state, sts[i]); end
      checks++; if (ALU_control !== alus[i]) begin errors++; $display("FAIL alu%0d_control got %0b exp %0b", i, ALU_control, alus[i]); end
      checks++; if ({ALU_srcA, ALU_srcB} !== {2'b10, srcb[i]}) begin errors++; $display("FAIL alu%0d_srcs got %0b exp %0b", i, {ALU_srcA, ALU_srcB}, {2'b10, srcb[i]}); end
      tick();
      #1;
      checks++; if ({state, reg_write, retired, result_select} !== {4'd7, 1'b1, 1'b1, 2'b00}) begin errors++; $display("FAIL alu%0d_aluwb got %0h exp %0h", i, {state, reg_write, retired, result_select}, {4'd7, 1'b1, 1'b1, 2'b00}); end
      tick();
      exp_instret++;
      #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL alu%0d_back_to_fetch got %0d exp 0", i, state); end
      checks++; if (instret !== exp_instret) begin errors++; $display("FAIL alu%0d_instret got %0d exp %0d", i, instret, exp_instret); end
    end
  endtask

  task automatic test_lw();
    issue(7'b0000011, 3'b010, 1'b0);
    tick();
    #1;
    checks++; if ({state, ALU_srcA, ALU_srcB, ALU_control} !== {4'd2, 2'b10, 2'b01, 3'b000}) begin errors++; $display("FAIL lw_memadr got %0h exp %0h", {state, ALU_srcA, ALU_srcB, ALU_control}, {4'd2, 2'b10, 2'b01, 3'b000}); end
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_bus.mem_ready = (i == 3);
      #1;
      checks++; if ({state, mem_bus.mem_read, mem_bus.adr_select} !== {4'd3, 1'b1, 1'b1}) begin errors++; $display("FAIL lw_memread%0d got %0h exp %0h", i, {state, mem_bus.mem_read, mem_bus.adr_select}, {4'd3, 1'b1, 1'b1}); end
      tick();
    end
    mem_bus.mem_ready = 1'b0;
    #1;
    checks++; if ({state, result_select, reg_write, retired} !== {4'd4, 2'b01, 1'b1, 1'b1}) begin errors++; $display("FAIL lw_memwb got %0h exp %0h", {state, result_select, reg_write, retired}, {4'd4, 2'b01, 1'b1, 1'b1}); end
    tick();
    exp_instret++;
    #1;
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL lw_instret got %0d exp %0d", instret, exp_instret); end
  endtask

  task automatic test_sw();
    issue(7'b0100011, 3'b010, 1'b0);
    tick();
    tick();
    #1;
    checks++; if ({state, mem_bus.mem_write, retired} !== {4'd5, 1'b1, 1'b0}) begin errors++; $display("FAIL sw_wait got %0h exp %0h", {state, mem_bus.mem_write, retired}, {4'd5, 1'b1, 1'b0}); end
    tick();
    mem_bus.mem_ready = 1'b1;
    #1;
    checks++; if ({mem_bus.mem_write, retired, reg_write} !== {1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL sw_done got %0b exp 110", {mem_bus.mem_write, retired, reg_write}); end
    tick();
    mem_bus.mem_ready = 1'b0;
    exp_instret++;
    #1;
    checks++; if ({state, instret} !== {4'd0, exp_instret}) begin errors++; $display("FAIL sw_fetch_instret got %0h exp %0h", {state, instret}, {4'd0, exp_instret}); end
  endtask

  task automatic test_beq();
    for (int i = 0; i < 2; i++) begin
      logic z;
      z = (i == 0);
      issue(7'b1100011, 3'b000, 1'b0);
      zero = z;
      tick();
      #1;
      checks++; if ({state, PC_write, retired, ALU_control} !== {4'd10, z, 1'b1, 3'b001}) begin errors++; $display("FAIL beq_zero%0b got %0h exp %0h", z, {state, PC_write, retired, ALU_control}, {4'd10, z, 1'b1, 3'b001}); end
      tick();
      exp_instret++;
      zero = 1'b0;
      #1;
      checks++; if (instret !== exp_instret) begin errors++; $display("FAIL beq_instret got %0d exp %0d", instret, exp_instret); end
    end
  endtask

  task automatic test_jal();
    issue(7'b1101111, 3'b000, 1'b0);
    tick();
    #1;
    checks++; if ({state, PC_write, ALU_srcA, ALU_srcB, retired} !== {4'd9, 1'b1, 2'b01, 2'b10, 1'b0}) begin errors++; $display("FAIL jal_state got %0h exp %0h", {state, PC_write, ALU_srcA, ALU_srcB, retired}, {4'd9, 1'b1, 2'b01, 2'b10, 1'b0}); end
    tick();
    #1;
    checks++; if ({state, reg_write, retired} !== {4'd7, 1'b1, 1'b1}) begin errors++; $display("FAIL jal_aluwb got %0h exp %0h", {state, reg_write, retired}, {4'd7, 1'b1, 1'b1}); end
    tick();
    exp_instret++;
    #1;
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL jal_instret got %0d exp %0d", instret, exp_instret); end
  endtask

  task automatic test_illegal();
    logic [6:0] ops[3] = '{7'b1110011, 7'b0110011, 7'b1100011};
    logic [2:0] f3s[3] = '{3'b000, 3'b001, 3'b001};
    logic [CW-1:0] frozen;
    for (int i = 0; i < 3; i++) begin
      frozen = exp_instret;
      issue(ops[i], f3s[i], 1'b0);
      #1;
      checks++; if (state !== 4'd1) begin errors++; $display("FAIL illegal%0d_decode got %0d exp 1", i, state); end
      tick();
      #1;
      checks++; if ({state, trap_cause} !== {4'd11, 2'b01}) begin errors++; $display("FAIL illegal%0d_trap got %0h exp %0h", i, {state, trap_cause}, {4'd11, 2'b01}); end
      mem_bus.mem_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick();
        #1;
        checks++; if ({mem_bus.mem_read, mem_bus.mem_write, IR_write, PC_write, reg_write, retired} !== 6'b0) begin errors++; $display("FAIL illegal%0d_strobes got %0b exp 0", i, {mem_bus.mem_read, mem_bus.mem_write, IR_write, PC_write, reg_write, retired}); end
        checks++; if ({state, trap_cause, instret} !== {4'd11, 2'b01, frozen}) begin errors++; $display("FAIL illegal%0d_held got %0h exp %0h", i, {state, trap_cause, instret}, {4'd11, 2'b01, frozen}); end
      end
      do_reset();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++; if ({state, mem_bus.mem_read} !== {4'd0, 1'b1}) begin errors++; $display("FAIL timeout_wait%0d got %0h exp %0h", k, {state, mem_bus.mem_read}, {4'd0, 1'b1}); end
      tick();
    end
    #1;
    checks++; if ({state, trap_cause, mem_bus.mem_read} !== {4'd11, 2'b10, 1'b0}) begin errors++; $display("FAIL timeout_trap got %0h exp %0h", {state, trap_cause, mem_bus.mem_read}, {4'd11, 2'b10, 1'b0}); end
    mem_bus.mem_ready = 1'b1;
    tick();
    #1;
    checks++; if ({state, IR_write, instret} !== {4'd11, 1'b0, {CW{1'b0}}}) begin errors++; $display("FAIL timeout_stuck got %0h exp %0h", {state, IR_write, instret}, {4'd11, 1'b0, {CW{1'b0}}}); end
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    for (int k = 0; k < 15; k++) tick();
    mem_bus.mem_ready = 1'b1;
    #1;
    checks++; if ({state, IR_write} !== {4'd0, 1'b1}) begin errors++; $display("FAIL boundary_ready got %0h exp %0h", {state, IR_write}, {4'd0, 1'b1}); end
    tick();
    mem_bus.mem_ready = 1'b0;
    #1;
    checks++; if ({state, trap_cause} !== {4'd1, 2'b00}) begin errors++; $display("FAIL boundary_no_trap got %0h exp %0h", {state, trap_cause}, {4'd1, 2'b00}); end
  endtask

  initial begin
    mem_bus.mem_ready = 1'b0;
    test_reset();
    test_alu_ops();
    test_lw();
    test_sw();
    test_beq();
    test_jal();
    test_illegal();
    test_timeout();
    test_timeout_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
